kronos_xif_dispatch: RTL

//  Multi-lane CV-X-IF front end for the Keccak coprocessor. Decodes offloaded instructions, binds

---
 rtl/kronos_xif_dispatch_if.sv | 54 +++++
 rtl/kronos_xif_dispatch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/kronos_xif_dispatch_if.sv
// Core-side CV-X-IF signals plus the per-lane engine bus for the Keccak dispatch block.
// The master modport is the environment (core + engines); the slave modport is the dispatcher.
interface kronos_xif_dispatch_if #(
   parameter int unsigned NUM_LANES  = 2,
   parameter int unsigned X_ID_WIDTH = 4,
   parameter int unsigned XLEN       = 32
);
   // issue channel
   logic                      issue_valid_i;
   logic                      issue_ready_o;
   logic [31:0]               issue_instr_i;
   logic [X_ID_WIDTH-1:0]     issue_id_i;
   logic [XLEN-1:0]           issue_rs1_i;
   logic [XLEN-1:0]           issue_rs2_i;
   logic                      issue_accept_o;
   logic                      issue_writeback_o;
   // commit channel
   logic                      commit_valid_i;
   logic [X_ID_WIDTH-1:0]     commit_id_i;
   logic                      commit_kill_i;
   // engine lanes
   logic [NUM_LANES-1:0]      lane_start_o;
   logic [NUM_LANES*10-1:0]   lane_funct_o;
   logic [NUM_LANES*XLEN-1:0] lane_rs1_o;
   logic [NUM_LANES*XLEN-1:0] lane_rs2_o;
   logic [NUM_LANES-1:0]      lane_done_i;
   logic [NUM_LANES*XLEN-1:0] lane_result_i;
   // result channel
   logic                      result_valid_o;
   logic                      result_ready_i;
   logic [X_ID_WIDTH-1:0]     result_id_o;
   logic [XLEN-1:0]           result_data_o;
   logic                      busy_o;

   modport master (
      output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
      input  issue_ready_o, issue_accept_o, issue_writeback_o,
      output commit_valid_i, commit_id_i, commit_kill_i,
      input  lane_start_o, lane_funct_o, lane_rs1_o, lane_rs2_o,
      output lane_done_i, lane_result_i,
      input  result_valid_o, result_id_o, result_data_o, busy_o,
      output result_ready_i
   );

   modport slave (
      input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
      output issue_ready_o, issue_accept_o, issue_writeback_o,
      input  commit_valid_i, commit_id_i, commit_kill_i,
      output lane_start_o, lane_funct_o, lane_rs1_o, lane_rs2_o,
      input  lane_done_i, lane_result_i,
      output result_valid_o, result_id_o, result_data_o, busy_o,
      input  result_ready_i
   );
endinterface

// File: rtl/kronos_xif_dispatch.sv
// Multi-lane CV-X-IF front end for the Keccak coprocessor: decodes offloaded instructions,
// binds them to free lanes, holds them until commit/kill, starts the engine and returns results
// through a completion-ordered FIFO. Every non-idle lane owns a reserved FIFO slot, so a
// draining lane can always push and the FIFO cannot overflow.
module kronos_xif_dispatch #(
   parameter int unsigned NUM_LANES  = 2,
   parameter int unsigned X_ID_WIDTH = 4,
   parameter int unsigned XLEN       = 32,
   parameter int unsigned RES_DEPTH  = 4,
   parameter logic [6:0]  OPCODE     = 7'h0B
) (
   input logic                clk_i,
   input logic                rst_i,
   kronos_xif_dispatch_if.slave xif
);

   localparam int unsigned PtrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(RES_DEPTH + 1);
   localparam int unsigned SumW = $clog2(RES_DEPTH + NUM_LANES + 1);

   typedef enum logic [1:0] {StIdle, StWaitCmt, StRun, StDrain} lane_state_e;

   lane_state_e           state_q  [NUM_LANES];
   lane_state_e           state_d  [NUM_LANES];
   logic [X_ID_WIDTH-1:0] id_q     [NUM_LANES];
   logic [9:0]            funct_q  [NUM_LANES];
   logic [XLEN-1:0]       rs1_q    [NUM_LANES];
   logic [XLEN-1:0]       rs2_q    [NUM_LANES];
   logic [XLEN-1:0]       result_q [NUM_LANES];
   logic [NUM_LANES-1:0]  start_q;

   logic [X_ID_WIDTH-1:0] fifo_id_q   [RES_DEPTH];
   logic [XLEN-1:0]       fifo_data_q [RES_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q;

   logic                  any_idle;
   logic [NUM_LANES-1:0]  bind_oh;
   logic [SumW-1:0]       busy_cnt;
   logic [SumW-1:0]       reserved;
   logic [NUM_LANES-1:0]  grant_oh;
   logic                  push;
   logic [X_ID_WIDTH-1:0] push_id;
   logic [XLEN-1:0]       push_data;
   logic                  pop;
   logic                  issue_ready;
   logic                  opcode_hit;
   logic                  issue_fire;
   logic                  accept_fire;
   logic                  commit_same;
   logic                  unused_instr;

   // Instruction fields not needed by the engines (register specifiers).
   assign unused_instr = ^{xif.issue_instr_i[24:15], xif.issue_instr_i[11:7]};

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (RES_DEPTH == 1) return '0;
      return (p == PtrW'(RES_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Lane occupancy: lowest idle lane for binding and number of lanes holding a reservation.
   always_comb begin
      any_idle = 1'b0;
      bind_oh  = '0;
      busy_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (state_q[i] == StIdle) begin
            if (!any_idle) bind_oh[i] = 1'b1;
            any_idle = 1'b1;
         end else begin
            busy_cnt = busy_cnt + SumW'(1);
         end
      end
   end

   // Push arbitration: lowest-index draining lane owns the single FIFO write port.
   always_comb begin
      grant_oh  = '0;
      push      = 1'b0;
      push_id   = '0;
      push_data = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (state_q[i] == StDrain && !push) begin
            grant_oh[i] = 1'b1;
            push        = 1'b1;
            push_id     = id_q[i];
            push_data   = result_q[i];
         end
      end
   end

   assign reserved    = SumW'(count_q) + busy_cnt;
   // Held low during reset so every output reads zero while rst_i is asserted.
   assign issue_ready = !rst_i && any_idle && (reserved < SumW'(RES_DEPTH));
   assign opcode_hit  = (xif.issue_instr_i[6:0] == OPCODE);
   assign issue_fire  = xif.issue_valid_i && issue_ready;
   assign accept_fire = issue_fire && opcode_hit;
   assign commit_same = xif.commit_valid_i && (xif.commit_id_i == xif.issue_id_i);
   assign pop         = (count_q != '0) && xif.result_ready_i;

   // Per-lane next state: bind, commit/kill, engine completion and FIFO grant.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            StIdle: begin
               if (accept_fire && bind_oh[i]) begin
                  // A commit arriving with the issue handshake is honoured immediately.
                  if (commit_same) state_d[i] = xif.commit_kill_i ? StIdle : StRun;
                  else             state_d[i] = StWaitCmt;
               end
            end
            StWaitCmt: begin
               if (xif.commit_valid_i && (xif.commit_id_i == id_q[i])) begin
                  state_d[i] = xif.commit_kill_i ? StIdle : StRun;
               end
            end
            StRun: begin
               if (xif.lane_done_i[i]) state_d[i] = StDrain;
            end
            StDrain: begin
               if (grant_oh[i]) state_d[i] = StIdle;
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   // Lane state, operand capture on bind, result capture on done, start pulse on RUN entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         start_q <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            state_q[i]  <= StIdle;
            id_q[i]     <= '0;
            funct_q[i]  <= '0;
            rs1_q[i]    <= '0;
            rs2_q[i]    <= '0;
            result_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            state_q[i] <= state_d[i];
            start_q[i] <= (state_d[i] == StRun) && (state_q[i] != StRun);
            if (accept_fire && bind_oh[i]) begin
               id_q[i]    <= xif.issue_id_i;
               funct_q[i] <= {xif.issue_instr_i[31:25], xif.issue_instr_i[14:12]};
               rs1_q[i]   <= xif.issue_rs1_i;
               rs2_q[i]   <= xif.issue_rs2_i;
            end
            if (state_q[i] == StRun && xif.lane_done_i[i]) begin
               result_q[i] <= xif.lane_result_i[i*XLEN +: XLEN];
            end
         end
      end
   end

   // Result FIFO storage and pointers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int k = 0; k < RES_DEPTH; k++) begin
            fifo_id_q[k]   <= '0;
            fifo_data_q[k] <= '0;
         end
      end else begin
         if (push) begin
            fifo_id_q[wr_ptr_q]   <= push_id;
            fifo_data_q[wr_ptr_q] <= push_data;
            wr_ptr_q              <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Output drive: issue response, flattened lane buses and FIFO head.
   always_comb begin
      xif.issue_ready_o     = issue_ready;
      xif.issue_accept_o    = accept_fire;
      xif.issue_writeback_o = accept_fire;
      xif.lane_start_o      = start_q;
      xif.lane_funct_o      = '0;
      xif.lane_rs1_o        = '0;
      xif.lane_rs2_o        = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         xif.lane_funct_o[i*10 +: 10]   = funct_q[i];
         xif.lane_rs1_o[i*XLEN +: XLEN] = rs1_q[i];
         xif.lane_rs2_o[i*XLEN +: XLEN] = rs2_q[i];
      end
      xif.result_valid_o = (count_q != '0);
      xif.result_id_o    = fifo_id_q[rd_ptr_q];
      xif.result_data_o  = fifo_data_q[rd_ptr_q];
      xif.busy_o         = (busy_cnt != '0) || (count_q != '0);
   end

endmodule
